mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/mem_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared configuration for the memory controller: rob tag width, access-size
// encodings, the I/O address region and small decode helpers.
package mem_ctrl_pkg;

  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Stores whose address bits [17:16] match this go to the I/O sink.
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    STORE
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic sext);
    case (size)
      SIZE_BYTE: extend = {{24{sext & raw[7]}}, raw[7:0]};
      SIZE_HALF: extend = {{16{sext & raw[15]}}, raw[15:0]};
      default:   extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller serving instruction fetches and LSB loads/stores,
// with round-robin arbitration, flush abort and I/O back-pressure on stores.
module mem_ctrl #(
  parameter int ROB_SIZE_WIDTH = mem_ctrl_pkg::ROB_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      rob_clear,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  output logic                      if_done,
  output logic [31:0]               if_data,
  input  logic                      lsb_req,
  input  logic                      lsb_we,
  input  logic [31:0]               lsb_addr,
  input  logic [1:0]                lsb_size,
  input  logic                      lsb_sext,
  input  logic [31:0]               lsb_wdata,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  output logic                      lsb_done,
  output logic [31:0]               lsb_rdata,
  output logic [ROB_SIZE_WIDTH-1:0] lsb_done_rob_id,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full
);
  import mem_ctrl_pkg::*;

  state_t                    state;
  logic [31:0]               addr;
  logic [1:0]                size;
  logic                      sext;
  logic [31:0]               wdata;
  logic [ROB_SIZE_WIDTH-1:0] rob_id;
  logic [2:0]                nbytes;
  logic [2:0]                cnt;
  logic [2:0]                next_idx;
  logic [31:0]               buf_data;
  logic [31:0]               read_word;
  logic [7:0]                store_byte;
  logic                      last_lsb;
  logic                      wr_en;
  logic                      io_hold;
  logic                      grant_lsb;
  logic                      accept;

  assign next_idx  = cnt + 3'd1;
  assign io_hold   = (mem_a[17:16] == IO_REGION) && io_buffer_full;
  assign mem_wr    = wr_en && !io_hold;
  assign grant_lsb = lsb_req && (!if_req || !last_lsb);
  assign accept    = (state == IDLE) && !rob_clear && !if_done && !lsb_done && (if_req || lsb_req);

  // cnt counts addresses issued; the byte landing on mem_din now belongs to cnt-1.
  always_comb begin
    read_word = buf_data;
    case (cnt)
      3'd1:    read_word[7:0]   = mem_din;
      3'd2:    read_word[15:8]  = mem_din;
      3'd3:    read_word[23:16] = mem_din;
      default: read_word[31:24] = mem_din;
    endcase
  end

  always_comb begin
    case (next_idx)
      3'd0:    store_byte = wdata[7:0];
      3'd1:    store_byte = wdata[15:8];
      3'd2:    store_byte = wdata[23:16];
      default: store_byte = wdata[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr            <= '0;
      size            <= '0;
      sext            <= 1'b0;
      wdata           <= '0;
      rob_id          <= '0;
      nbytes          <= '0;
      cnt             <= '0;
      buf_data        <= '0;
      last_lsb        <= 1'b0;
      wr_en           <= 1'b0;
      if_done         <= 1'b0;
      if_data         <= '0;
      lsb_done        <= 1'b0;
      lsb_rdata       <= '0;
      lsb_done_rob_id <= '0;
      mem_dout        <= '0;
      mem_a           <= '0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            buf_data <= '0;
            if (grant_lsb) begin
              last_lsb <= 1'b1;
              addr     <= lsb_addr;
              mem_a    <= lsb_addr;
              size     <= lsb_size;
              sext     <= lsb_sext;
              wdata    <= lsb_wdata;
              rob_id   <= lsb_rob_id;
              nbytes   <= size_bytes(lsb_size);
              if (lsb_we) begin
                state    <= STORE;
                wr_en    <= 1'b1;
                mem_dout <= lsb_wdata[7:0];
              end else begin
                state <= LOAD;
              end
            end else begin
              last_lsb <= 1'b0;
              addr     <= if_addr;
              mem_a    <= if_addr;
              nbytes   <= 3'd4;
              state    <= FETCH;
            end
          end
        end
        FETCH, LOAD: begin
          if (rob_clear) begin
            state <= IDLE;
          end else begin
            if (cnt != 3'd0) buf_data <= read_word;
            if (cnt == nbytes) begin
              state <= IDLE;
              if (state == FETCH) begin
                if_done <= 1'b1;
                if_data <= read_word;
              end else begin
                lsb_done        <= 1'b1;
                lsb_rdata       <= extend(read_word, size, sext);
                lsb_done_rob_id <= rob_id;
              end
            end else begin
              cnt <= next_idx;
              if (next_idx < nbytes) mem_a <= addr + {29'b0, next_idx};
            end
          end
        end
        STORE: begin
          // A flush cannot cancel a store; only I/O back-pressure stalls it.
          if (!io_hold) begin
            if (cnt == nbytes - 3'd1) begin
              wr_en           <= 1'b0;
              state           <= IDLE;
              lsb_done        <= 1'b1;
              lsb_done_rob_id <= rob_id;
            end else begin
              cnt      <= next_idx;
              mem_a    <= addr + {29'b0, next_idx};
              mem_dout <= store_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
